// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader that writes big-endian words into instruction memory
// Holds the CPU in reset while a count/payload/checksum stream is written word by word.
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  WA,
  output logic [31:0] WD,
  output logic        WE,
  output logic        busy,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_BYTES,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic        in_ready_q, in_ready_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COUNT;
          wa_d    = BASE_ADDR;
          err_d   = 1'b0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          rem_d   = in_data;
          acc_d   = 8'h00;
          idx_d   = 2'd0;
          state_d = (in_data != 8'h00) ? S_BYTES : S_CHECK;
        end
      end
      S_BYTES: begin
        // Bytes arrive MSB first, so shifting left assembles a big-endian word.
        if (xfer) begin
          wd_d  = {wd_q[23:0], in_data};
          acc_d = acc_q ^ in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wa_d    = wa_q + 8'd1;
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? S_CHECK : S_BYTES;
      end
      S_CHECK: begin
        if (xfer) begin
          err_d   = (in_data != acc_q);
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies decoded from the next state.
    in_ready_d = (state_d == S_COUNT) || (state_d == S_BYTES) || (state_d == S_CHECK);
    we_d       = (state_d == S_WRITE);
    busy_d     = (state_d == S_COUNT) || (state_d == S_BYTES) ||
                 (state_d == S_WRITE) || (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wa_q       <= BASE_ADDR;
      wd_q       <= 32'h0000_0000;
      rem_q      <= 8'h00;
      acc_q      <= 8'h00;
      idx_q      <= 2'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign WA        = wa_q;
  assign WD        = wd_q;
  assign WE        = we_q;
  assign busy      = busy_q;
  assign cpu_reset = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
// Two instances (base 00 and FE) share one stream so address wrap is checked on every load.
module tb_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, WE, busy, cpu_reset, done, err;
  logic [7:0]  WA;
  logic [31:0] WD;
  logic        in_ready_f, WE_f, busy_f, cpu_reset_f, done_f, err_f;
  logic [7:0]  WA_f;
  logic [31:0] WD_f;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  int we_cnt_f = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .WA(WA), .WD(WD), .WE(WE), .busy(busy),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  imem_loader #(.BASE_ADDR(8'hFE)) dut_f (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_f), .WA(WA_f), .WD(WD_f), .WE(WE_f), .busy(busy_f),
    .cpu_reset(cpu_reset_f), .done(done_f), .err(err_f)
  );

  always @(negedge clk) begin
    if (WE === 1'b1) we_cnt++;
    if (WE_f === 1'b1) we_cnt_f++;
  end

  function automatic bq_t make_stream(input wq_t words, input bit bad, input logic [7:0] bad_chk);
    bq_t s;
    logic [7:0] x = 8'h00;
    s.push_back(8'(words.size()));
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        s.push_back(words[i][8*k +: 8]);
        x ^= words[i][8*k +: 8];
      end
    end
    s.push_back(bad ? bad_chk : x);
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int waited = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference: word i lands at base+i (mod 256), err is checksum != XOR of payload bytes.
  task automatic run_load(input bq_t s, input int gap_pct, input bit poke);
    int n = int'(s[0]);
    int we0 = we_cnt;
    int we0f = we_cnt_f;
    logic [7:0]  x = 8'h00;
    logic [31:0] w_exp;
    logic [7:0]  a_exp, af_exp;
    logic        err_exp;

    pulse_start();
    vectors++;
    if ({busy, cpu_reset, in_ready, done, err, busy_f} !== 6'b111001) begin
      miscompares++;
      $display("FAIL start_state: busy=%b cpu_reset=%b rdy=%b done=%b err=%b busy_f=%b, want 1 1 1 0 0 1",
               busy, cpu_reset, in_ready, done, err, busy_f);
    end
    send_byte(s[0], gap_pct);
    if (poke) begin
      pulse_start();
      vectors++;
      if ({busy, in_ready} !== 2'b11) begin
        miscompares++;
        $display("FAIL start_while_busy: busy=%b rdy=%b, want 1 1", busy, in_ready);
      end
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        w_exp[8*(3-k) +: 8] = s[1 + 4*w + k];
        x ^= s[1 + 4*w + k];
        send_byte(s[1 + 4*w + k], gap_pct);
      end
      a_exp  = 8'(w);
      af_exp = 8'hFE + 8'(w);
      vectors++;
      if ({WE, WA, WD, WE_f, WA_f, WD_f, in_ready} !== {1'b1, a_exp, w_exp, 1'b1, af_exp, w_exp, 1'b0}) begin
        miscompares++;
        $display("FAIL write_word%0d: got WE=%b WA=%h WD=%h WA_f=%h WD_f=%h rdy=%b, want WE=1 WA=%h WD=%h WA_f=%h rdy=0",
                 w, WE, WA, WD, WA_f, WD_f, in_ready, a_exp, w_exp, af_exp);
      end
    end
    send_byte(s[4*n + 1], gap_pct);
    err_exp = (s[4*n + 1] != x);
    vectors++;
    if ({done, busy, cpu_reset, in_ready, err, done_f, err_f} !== {4'b1000, err_exp, 1'b1, err_exp}) begin
      miscompares++;
      $display("FAIL finish: done=%b busy=%b cpu_reset=%b rdy=%b err=%b done_f=%b err_f=%b, want 1 0 0 0 %b 1 %b",
               done, busy, cpu_reset, in_ready, err, done_f, err_f, err_exp, err_exp);
    end
    @(negedge clk);
    vectors++;
    if ((we_cnt - we0) != n || (we_cnt_f - we0f) != n) begin
      miscompares++;
      $display("FAIL we_count: got %0d/%0d pulses, want %0d", we_cnt - we0, we_cnt_f - we0f, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({in_ready, WE, WA, WD, busy, cpu_reset, done, err} !== {2'b00, 8'h00, 32'h0, 4'b0000}
        || {in_ready_f, WE_f, WA_f, WD_f, busy_f, done_f, err_f} !== {2'b00, 8'hFE, 32'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b WE=%b WA=%h WD=%h busy=%b cpu_reset=%b done=%b err=%b WA_f=%h, want 0 0 00 0 0 0 0 0 FE",
               in_ready, WE, WA, WD, busy, cpu_reset, done, err, WA_f);
    end
  endtask

  task automatic test_single_word();
    wq_t w = '{32'h2001_0003};
    run_load(make_stream(w, 1'b0, 8'h00), 0, 1'b0);
  endtask

  task automatic test_five_word();
    wq_t w = '{32'h2001_0003, 32'h2002_0009, 32'h0022_1020, 32'h0022_1824, 32'h0022_2025};
    run_load(make_stream(w, 1'b0, 8'h00), 0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    wq_t w = '{32'h2001_0003};
    run_load(make_stream(w, 1'b1, 8'h00), 0, 1'b0);
  endtask

  task automatic test_backpressure();
    wq_t w;
    bq_t s;
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    s = make_stream(w, 1'b0, 8'h00);
    run_load(s, 0, 1'b0);
    run_load(s, 45, 1'b1);
  endtask

  task automatic test_zero_count();
    wq_t w;
    run_load(make_stream(w, 1'b0, 8'h00), 0, 1'b0);
  endtask

  task automatic test_wrap();
    wq_t w = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    run_load(make_stream(w, 1'b0, 8'h00), 20, 1'b0);
  endtask

  task automatic test_mid_reset();
    wq_t w = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    bq_t s = make_stream(w, 1'b0, 8'h00);
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(s[i], 0);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, WE, WA, WD, busy, cpu_reset, done, err} !== {2'b00, 8'h00, 32'h0, 4'b0000}
        || {in_ready_f, WE_f, WA_f, WD_f, busy_f, done_f, err_f} !== {2'b00, 8'hFE, 32'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL mid_reset: rdy=%b WE=%b WA=%h WD=%h busy=%b cpu_reset=%b done=%b err=%b WA_f=%h, want 0 0 00 0 0 0 0 0 FE",
               in_ready, WE, WA, WD, busy, cpu_reset, done, err, WA_f);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    run_load(s, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int l = 0; l < 4; l++) begin
      wq_t w;
      int n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load(make_stream(w, ($urandom_range(3) == 0), 8'($urandom)), (l % 2) * 30, 1'b0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_single_word();
    test_five_word();
    test_bad_checksum();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into the instruction memory's write port at consecutive word addresses, and the payload is verified against a trailing XOR checksum. While loading, it holds the processor in reset so fetch never sees a half-written program.

## Interface
Parameters:
- BASE_ADDR, 8'h00, word address of the first instruction written.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when in IDLE or DONE, ignored otherwise.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- WA  output  8  instruction memory write word address.
- WD  output  32  instruction memory write data.
- WE  output  1  instruction memory write enable, single-cycle pulse per word.
- busy  output  1  load in progress.
- cpu_reset  output  1  holds the processor in reset; equals busy.
- done  output  1  load finished; held until next start or reset.
- err  output  1  checksum mismatch on last load; valid when done=1.

## Operation
- Stream format: count byte N (0..255 words), then 4·N payload bytes (MSB first per word), then one checksum byte equal to the XOR of all payload bytes. The count byte is excluded from the checksum.
- A byte transfers on a clock edge with in_valid && in_ready. No transfer happens otherwise; all state holds.
- States:
  - IDLE: no activity. Goes to COUNT on start.
  - COUNT: in_ready=1. On transfer, latch N and clear the checksum accumulator. Go to BYTES if N≠0, else CHECK.
  - BYTES: in_ready=1. Shift the byte into the word register and XOR it into the accumulator. After the 4th byte, go to WRITE.
  - WRITE: in_ready=0, WE=1 for exactly one cycle with the current WA/WD. Then WA increments and the remaining count decrements. If words remain, go to BYTES, else CHECK.
  - CHECK: in_ready=1. On transfer, err ← (byte ≠ accumulator). Go to DONE.
  - DONE: done=1, busy=0. A start pulse clears done/err, sets WA=BASE_ADDR, and goes to COUNT.
- WA is 8 bits and wraps 8'hFF→8'h00 with no error.
- Words are written even if the checksum later fails; err reports the failure, and the processor is released regardless.
- start while busy: ignored.

## Timing
- Reset values: state IDLE, in_ready=0, WE=0, WA=BASE_ADDR, WD=0, busy=0, cpu_reset=0, done=0, err=0, byte index 0, accumulator 0.
- busy/cpu_reset rise the cycle after start is sampled and fall the same cycle done rises.
- WE asserts the cycle after the 4th byte of a word transfers. WA/WD are stable in that cycle. Minimum 5 cycles per word at full rate.
- done rises the cycle after the checksum byte transfers.
- Registered outputs only; in_ready depends only on state, never on in_valid.
- A reset asserted mid-load aborts it immediately. Next cycle all outputs are at reset values. Partially written memory contents are not cleaned up.

## Test plan
- Single word: start, bytes 01, 20 01 00 03, 22 → one WE pulse with WA=00, WD=0x20010003; then done=1, err=0, cpu_reset low.
- Five-word program: N=05, words 0x20010003, 0x20020009, 0x00221020, 0x00221824, 0x00222025, correct checksum → WE at WA=00..04 with matching WD; done=1, err=0.
- Bad checksum: same as single word, but checksum byte 00 → word still written at WA=00; done=1, err=1.
- Back-pressure and gaps: random in_valid gaps and a byte offered during WRITE (in_ready=0) → byte not consumed, identical WA/WD sequence to the gap-free run.
- N=00 then checksum 00 → no WE, done=1, err=0. With BASE_ADDR=8'hFE and N=3 → writes at FE, FF, 00.
- Reset after 2 bytes of word 2 → next cycle all outputs at reset values. A later fresh start plus a full stream loads correctly from BASE_ADDR.
